aes_inv_sub_bytes_seq: RTL and testbench
========================================

Name: aes_inv_sub_bytes_seq

Overview:
- Sequential AES InvSubBytes engine for the decrypt datapath; inverse counterpart of the forward byte-substitution unit.
- Accepts one 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through the FIPS-197 inverse S-box.
- Presents the 128-bit result over a second valid/ready handshake.
- Sits between AddRoundKey/InvShiftRows and InvMixColumns in the iterative decryption core.

Parameters:
- LANES, 4: bytes substituted per BUSY cycle. Legal values are 1, 2, 4, 8 and 16. Any other value stops elaboration via a generate-time error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a state this cycle
- in_data  input  128  input state; byte k = in_data[127-8k -: 8] (byte 0 = MSB, FIPS-197 order)
- out_valid  output  1  out_data holds a complete result
- out_ready  input  1  downstream accepts the result
- out_data  output  128  substituted state, same byte order as in_data
- busy  output  1  high while in BUSY state

Behaviour:
- Reset (rst=1 at a clk edge) overrides everything, including mid-operation: state=IDLE, lane counter=0, out_valid=0, busy=0, out_data=128'h0, internal state register cleared. in_ready is 1 in the cycle after reset is released.
- Reset is synchronous only; rst is never in any sensitivity list.
- Inverse S-box: 256-entry constant table per lane, combinational lookup, held inside this block.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the working register, clear the lane counter, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register are replaced by their inverse S-box values and cnt increments. After the cycle with cnt=16/LANES-1, go to DONE. in_valid and out_ready are ignored in this state.
  - DONE: out_valid=1 and out_data = working register, stable until accepted.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1 in the same cycle: in_ready=1 combinationally, the new state is captured, and the FSM goes directly to BUSY (back-to-back, no IDLE bubble).
    - out_ready=0: in_ready=0.
- Latency: input handshake at edge N produces out_valid=1 from edge N+16/LANES onward.
  - LANES=4: 4 cycles.
  - LANES=16: 1 cycle.
  - LANES=1: 16 cycles.
- Sustained throughput: one state per 16/LANES+1 cycles when out_ready is held high and in_valid is always asserted.
- out_data updates only on capture into DONE. Outside DONE it keeps its last value; it is not meaningful while out_valid=0.
- Lane counter width is $clog2(16/LANES), minimum 1 bit. The counter wraps to 0 on entry to BUSY and never overflows.
- in_ready, out_valid and busy are registered or pure state decodes, except the DONE-state in_ready term, which depends combinationally on out_ready.
- No combinational path from in_data to out_data.

Test Plan:
- Reset, then in_data=128'h63636363_63636363_63636363_63636363 with LANES=4 → out_valid rises 4 cycles after the handshake; out_data=128'h0; busy high for exactly 4 cycles.
- in_data = 0x84 in byte 0, 0x00 in bytes 1-15 → out_data=128'h4f525252_52525252_52525252_52525252.
- in_data=128'h637c777b_f26b6fc5_3001672b_fed7ab76 → out_data=128'h00010203_04050607_08090a0b_0c0d0e0f. Repeat with LANES=1 (latency 16), LANES=2, LANES=8 and LANES=16 (latency 1); results are identical.
- out_ready=0 for 10 cycles in DONE: out_valid stays 1, out_data stable, in_ready=0, a pending in_valid is not taken. Then raise out_ready together with in_valid for in_data=128'h16161616_16161616_16161616_16161616: same-cycle handoff, next result=128'hffffffff_ffffffff_ffffffff_ffffffff.
- Assert rst for one cycle while in BUSY with cnt=2 → next cycle: IDLE, busy=0, out_valid=0, out_data=0, in_ready=1. A fresh transaction then completes correctly.
- Randomised: 1000 random states with random in_valid/out_ready gaps. Each output is compared against a forward S-box reference model; the forward S-box of each output byte equals the corresponding input byte; no transaction is lost or duplicated.

Source files
------------

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: captures a 128-bit state, substitutes LANES
// bytes per cycle through the inverse S-box, then holds the result until accepted.
module aes_inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int            STEPS = 16 / LANES;
  localparam int            CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [15:0][7:0] work_q;   // FIPS byte k lives at index 15-k
  logic [15:0][7:0] sub_d;
  logic [127:0]     out_data_q;
  logic             out_valid_q;
  logic             busy_q;

  // NOTE: sub_d gets a full default before the loop, so no latch is inferred.
  always_comb begin
    logic [3:0] idx;
    sub_d = work_q;
    idx   = '0;
    for (int l = 0; l < LANES; l++) begin
      idx        = 4'(15 - (int'(cnt_q) * LANES + l));
      sub_d[idx] = inv_sbox(work_q[idx]);
    end
  end

  // NOTE: state registers use non-blocking assignments only; the synchronous
  // reset also clears the working register so no stale state leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            work_q  <= in_data;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          work_q <= sub_d;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= sub_d;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            // Same-cycle handoff: accept the next state without an IDLE bubble.
            if (in_valid) begin
              work_q  <= in_data;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_BUSY;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for aes_inv_sub_bytes_seq: directed vectors across all LANES values,
// back-pressure/reset corner cases, and random traffic against a GF(2^8) model.
module tb_aes_inv_sub_bytes_seq;

  localparam int NDUT  = 5;
  localparam int NRAND = 1000;

  function automatic int lanes_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  logic              clk;
  logic              rst;
  logic [NDUT-1:0]   in_valid;
  logic [NDUT-1:0]   out_ready;
  logic [127:0]      in_data [NDUT];
  wire  [NDUT-1:0]   in_ready;
  wire  [NDUT-1:0]   out_valid;
  wire  [NDUT-1:0]   busy;
  wire  [127:0]      out_data [NDUT];

  int n_vec;
  int n_bad;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = lanes_of(g);
    aes_inv_sub_bytes_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: S-box from field inversion plus the affine transform.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] map_state(input logic [127:0] s, input logic inverse);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = inverse ? inv_tbl[s[127-8*k -: 8]] : fwd_tbl[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected event, none required", name);
  endtask

  // All tasks are entered and left 1 time unit after a rising edge unless noted.
  task automatic send(input int i, input logic [127:0] d, output logic ok);
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    ok          = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready[i]) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid[i] = 1'b0;
  endtask

  // Leaves at the falling edge where out_valid was first seen.
  task automatic wait_out(input int i, output int lat, output int busy_n, output logic [127:0] dat);
    lat    = -1;
    busy_n = 0;
    dat    = '0;
    for (int j = 0; j < 40 && lat < 0; j++) begin
      @(negedge clk);
      if (out_valid[i]) begin
        lat = j;
        dat = out_data[i];
      end else begin
        if (busy[i]) busy_n++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic accept(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic run_vec(input int i, input logic [127:0] din, input logic [127:0] dout,
                         input string tag);
    logic         ok;
    int           lat;
    int           bn;
    int           steps;
    logic [127:0] got;
    steps = 16 / lanes_of(i);
    send(i, din, ok);
    check({tag, "_handshake"}, 128'(ok), 128'd1);
    wait_out(i, lat, bn, got);
    check({tag, "_data"}, got, dout);
    check({tag, "_latency"}, 128'(lat), 128'(steps));
    check({tag, "_busy_cycles"}, 128'(bn), 128'(steps));
    accept(i);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;

  vec_t         vecs [5];
  logic [127:0] src_q [$];
  int           n_recv;

  initial begin
    logic         ok;
    int           lat;
    int           bn;
    int           bad_v;
    int           bad_d;
    int           bad_r;
    logic [127:0] got;

    n_vec = 0;
    n_bad = 0;
    n_recv = 0;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] r;
      b = 8'(x);
      r = 8'h01;
      for (int e = 0; e < 254; e++) r = gmul(r, b);
      fwd_tbl[x] = r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
      inv_tbl[fwd_tbl[x]] = 8'(x);
    end

    vecs[0] = '{128'h63636363_63636363_63636363_63636363, 128'h0, "all_63"};
    vecs[1] = '{128'h84000000_00000000_00000000_00000000,
                128'h4f525252_52525252_52525252_52525252, "byte0_84"};
    vecs[2] = '{128'h637c777b_f26b6fc5_3001672b_fed7ab76,
                128'h00010203_04050607_08090a0b_0c0d0e0f, "fips_seq"};
    vecs[3] = '{128'h16161616_16161616_16161616_16161616,
                128'hffffffff_ffffffff_ffffffff_ffffffff, "all_16"};
    vecs[4] = '{128'h0, 128'h52525252_52525252_52525252_52525252, "all_00"};

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < NDUT; i++) in_data[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready[0]), 128'd1);
    check("reset_out_valid", 128'(out_valid[0]), 128'd0);
    check("reset_busy", 128'(busy[0]), 128'd0);
    check("reset_out_data", out_data[0], 128'h0);
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_vec(0, vecs[v].din, vecs[v].dout, vecs[v].name);

    for (int i = 1; i < NDUT; i++)
      run_vec(i, vecs[2].din, vecs[2].dout, $sformatf("lanes%0d", lanes_of(i)));

    // Back-pressure in DONE, then same-cycle handoff.
    send(0, vecs[2].din, ok);
    check("stall_handshake", 128'(ok), 128'd1);
    wait_out(0, lat, bn, got);
    check("stall_first_data", got, vecs[2].dout);
    in_data[0]  = vecs[3].din;
    in_valid[0] = 1'b1;
    bad_v = 0;
    bad_d = 0;
    bad_r = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1) bad_v++;
      if (out_data[0] !== vecs[2].dout) bad_d++;
      if (in_ready[0] !== 1'b0) bad_r++;
    end
    check("stall_out_valid_dropped", 128'(bad_v), 128'd0);
    check("stall_out_data_changed", 128'(bad_d), 128'd0);
    check("stall_in_ready_high", 128'(bad_r), 128'd0);
    out_ready[0] = 1'b1;
    #1;
    check("handoff_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    wait_out(0, lat, bn, got);
    check("handoff_data", got, vecs[3].dout);
    check("handoff_latency", 128'(lat), 128'd4);
    accept(0);

    // Reset while BUSY with the lane counter at 2.
    send(0, vecs[2].din, ok);
    check("midrst_handshake", 128'(ok), 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_busy_before", 128'(busy[0]), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 128'(busy[0]), 128'd0);
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_out_data", out_data[0], 128'h0);
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    run_vec(0, vecs[1].din, vecs[1].dout, "after_midrst");

    // Random traffic with gaps on both handshakes.
    fork
      begin : drv
        logic [127:0] d;
        logic         taken;
        for (int n = 0; n < NRAND; n++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          in_data[0]  = d;
          in_valid[0] = 1'b1;
          taken       = 1'b0;
          for (int c = 0; c < 200 && !taken; c++) begin
            @(negedge clk);
            if (in_ready[0]) begin
              taken = 1'b1;
              src_q.push_back(d);
            end
            @(posedge clk); #1;
          end
          in_valid[0] = 1'b0;
          if (!taken) begin
            fail_now("rand_input_stuck");
            break;
          end
        end
      end
      begin : mon
        logic [127:0] s;
        int           cyc;
        cyc = 0;
        while (n_recv < NRAND && cyc < 30000) begin
          out_ready[0] = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid[0] && out_ready[0]) begin
            if (src_q.size() == 0) begin
              fail_now("rand_spurious_output");
            end else begin
              s = src_q.pop_front();
              check($sformatf("rand_data_%0d", n_recv), out_data[0], map_state(s, 1'b1));
              check($sformatf("rand_fwd_%0d", n_recv), map_state(out_data[0], 1'b0), s);
            end
            n_recv++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        out_ready[0] = 1'b0;
      end
    join

    check("rand_received", 128'(n_recv), 128'(NRAND));
    check("rand_leftover", 128'(src_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
